mc_control_fsm: RTL

Parametrised multi-cycle control unit for the RV32I core. It sequences FETCH/DECODE/EXECUTE/MEM/WB for every instruction, the same way the current multi-cycle controller does. It adds ready/request handshakes toward instruction and data memory, a per-wait timeout with a sticky fault, and illegal-opcode trapping. Multiply/divide sequencing is an optional compile-time feature. It sits between the instruction register and the multi-cycle datapath and drives every datapath enable and mux select.

---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_wait_timer.sv | 28 ++
 rtl/mc_control_fsm.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU and
// write-back select codes, fault causes and the FSM state enum.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] RFWD_ALU   = 3'b000;
  localparam logic [2:0] RFWD_MEM   = 3'b001;
  localparam logic [2:0] RFWD_LUI   = 3'b010;
  localparam logic [2:0] RFWD_AUIPC = 3'b011;
  localparam logic [2:0] RFWD_PC4   = 3'b100;
  localparam logic [2:0] RFWD_MDU   = 3'b101;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_ILLEGAL,
    FC_IMEM_TO,
    FC_DMEM_TO
  } fault_cause_e;

  typedef enum logic [4:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE,
    JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, M_EXE, FAULT
  } state_e;

  function automatic logic [3:0] alu_default(input logic bit30, input logic [2:0] funct3);
    return {bit30, funct3};
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating wait-cycle counter; expired flags the last allowed not-ready
// cycle. MEM_TIMEOUT = 0 never expires.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM with memory handshakes, wait timeout and
// illegal-opcode trapping. Define MC_MULDIV_EN to enable M-extension sequencing.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        mdu_done,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic        dataWe,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        PCEn,
  output logic [3:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        mdu_start,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [4:0]  state_o
);

  state_e       state, next_state;
  fault_cause_e cause_q, cause_d;
  logic         wait_cycle, expired;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [3:0]   alu_dflt;
  logic         is_muldiv;
  logic         unused_bits;

  assign opcode    = instrCode[6:0];
  assign funct3    = instrCode[14:12];
  assign alu_dflt  = alu_default(instrCode[30], funct3);
  assign is_muldiv = (instrCode[31:25] == FUNCT7_MULDIV);

  // Kept outside the decode block so the timer's expired flag depends on registers only.
  assign wait_cycle = ((state == FETCH) && !imem_ready) ||
                      (((state == S_MEM) || (state == L_MEM)) && !dmem_ready);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (next_state != state),
    .count  (wait_cycle),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      cause_q <= FC_NONE;
    end else begin
      state   <= next_state;
      cause_q <= cause_d;
    end
  end

`ifdef MC_MULDIV_EN
  logic mdu_started;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_started <= 1'b0;
    end else begin
      mdu_started <= (state == M_EXE) && (next_state == M_EXE);
    end
  end

  assign unused_bits = ^{instrCode[24:15], instrCode[11:7]};
`else
  assign unused_bits = ^{instrCode[24:15], instrCode[11:7], mdu_done};
`endif

  always_comb begin
    next_state    = state;
    cause_d       = cause_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    dataWe        = 1'b0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    PCEn          = 1'b0;
    aluControl    = '0;
    RFWDSrcMuxSel = RFWD_ALU;
    mdu_start     = 1'b0;

    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          PCEn       = 1'b1;
          next_state = DECODE;
        end else if (expired) begin
          next_state = FAULT;
          cause_d    = FC_IMEM_TO;
        end
      end
      DECODE: begin
        case (opcode)
          OP_TYPE_R: begin
            if (is_muldiv) begin
`ifdef MC_MULDIV_EN
              next_state = M_EXE;
`else
              next_state = FAULT;
              cause_d    = FC_ILLEGAL;
`endif
            end else begin
              next_state = R_EXE;
            end
          end
          OP_TYPE_I:  next_state = I_EXE;
          OP_TYPE_B:  next_state = B_EXE;
          OP_TYPE_LU: next_state = LU_EXE;
          OP_TYPE_AU: next_state = AU_EXE;
          OP_TYPE_J:  next_state = J_EXE;
          OP_TYPE_JL: next_state = JL_EXE;
          OP_TYPE_S:  next_state = S_EXE;
          OP_TYPE_L:  next_state = L_EXE;
          default: begin
            next_state = FAULT;
            cause_d    = FC_ILLEGAL;
          end
        endcase
      end
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = alu_dflt;
        next_state = FETCH;
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // bit 30 is immediate data except for the shift-right pair
        aluControl   = (funct3 == 3'b101) ? alu_dflt : {1'b0, funct3};
        next_state   = FETCH;
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = alu_dflt;
        next_state = FETCH;
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_LUI;
        aluControl    = alu_dflt;
        next_state    = FETCH;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_AUIPC;
        aluControl    = alu_dflt;
        next_state    = FETCH;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
        aluControl    = alu_dflt;
        next_state    = FETCH;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        jal           = 1'b1;
        jalr          = 1'b1;
        aluControl    = ALU_ADD;
        next_state    = FETCH;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        aluControl   = ALU_ADD;
        next_state   = S_MEM;
      end
      S_MEM: begin
        dataWe     = 1'b1;
        dmem_req   = 1'b1;
        aluControl = ALU_ADD;
        if (dmem_ready) begin
          next_state = FETCH;
        end else if (expired) begin
          next_state = FAULT;
          cause_d    = FC_DMEM_TO;
        end
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_MEM;
        aluControl    = ALU_ADD;
        next_state    = L_MEM;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_MEM;
        dmem_req      = 1'b1;
        aluControl    = ALU_ADD;
        if (dmem_ready) begin
          next_state = L_WB;
        end else if (expired) begin
          next_state = FAULT;
          cause_d    = FC_DMEM_TO;
        end
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_MEM;
        aluControl    = ALU_ADD;
        next_state    = FETCH;
      end
`ifdef MC_MULDIV_EN
      M_EXE: begin
        mdu_start  = !mdu_started;
        aluControl = alu_dflt;
        if (mdu_done) begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = RFWD_MDU;
          next_state    = FETCH;
        end
      end
`endif
      FAULT: begin
        next_state = FAULT;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  assign fault       = (state == FAULT);
  assign fault_cause = cause_q;
  assign state_o     = state;

endmodule
